// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between NREQ requesters, with a fixed read-return pipeline.
// Optional `VRAM_ARB_VGA_PRIO_EN: requester 0 (VGA fetch) wins whenever eligible; others round-robin.
module vram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] elig;
    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cidx;
    int              cand;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;

    logic            s1_valid;
    logic [PW-1:0]   s1_owner;
    logic            s2_valid;
    logic [PW-1:0]   s2_owner;

    // A requester granted last cycle sits out this one, so it can drop or replace its request.
    always_comb begin
        elig  = req & ~gnt;
        found = 1'b0;
        win   = '0;
        cand  = 0;
        cidx  = '0;
`ifdef VRAM_ARB_VGA_PRIO_EN
        if (elig[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cidx = PW'(cand);
            if (!found && elig[cidx]) begin
                found = 1'b1;
                win   = cidx;
            end
        end
        ptr_next = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_we    = req_we[i];
            end
        end
    end

    // Reads travel two stages behind the grant so rdata lines up with the BRAM's one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            s1_valid  <= 1'b0;
            s1_owner  <= '0;
            s2_valid  <= 1'b0;
            s2_owner  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
            rvalid   <= '0;
            if (s2_valid) begin
                rvalid[s2_owner] <= 1'b1;
                rdata            <= mem_rdata;
            end
            gnt <= '0;
            if (found) begin
                gnt[win]  <= 1'b1;
                mem_addr  <= sel_addr;
                mem_we    <= sel_we;
                mem_wdata <= sel_wdata;
                s1_valid  <= ~sel_we;
                s1_owner  <= win;
`ifdef VRAM_ARB_VGA_PRIO_EN
                if (win != '0) ptr <= ptr_next;
`else
                ptr <= ptr_next;
`endif
            end else begin
                mem_we   <= 1'b0;
                s1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter: a spec-level model predicts grants and read returns; a monitor checks them.
// Honours `VRAM_ARB_VGA_PRIO_EN the same way the design does.
module tb_vram_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    vram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] gnt;
        logic [AW-1:0]   addr;
        logic            we;
        logic [DW-1:0]   wdata;
    } exp_t;

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];

    logic [DW-1:0] bram      [0:65535];
    logic [DW-1:0] model_mem [0:65535];

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;

    int              m_ptr;
    logic [NREQ-1:0] m_gnt;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'((a * 37) ^ (a >> 3) ^ 12'h5C3);
    endfunction

    // Simple read-first BRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_n, act, exp);
        end
    endtask

    // Predicts what the arbiter should present after the coming clock edge from the request rules alone.
    function automatic void model_step();
        exp_t            e;
        rd_t             r;
        logic [NREQ-1:0] elig;
        int              win;
        int              upcoming;
        upcoming = edge_n + 1;
        if (rst) begin
            m_ptr   = 0;
            m_gnt   = '0;
            m_addr  = '0;
            m_wdata = '0;
            e = '{rst: 1'b1, gnt: '0, addr: '0, we: 1'b0, wdata: '0};
            while (rd_q.size() > 0 && rd_q[$].due >= upcoming) void'(rd_q.pop_back());
        end else begin
            elig = req & ~m_gnt;
            win  = -1;
`ifdef VRAM_ARB_VGA_PRIO_EN
            if (elig[0]) win = 0;
`endif
            for (int k = 0; k < NREQ; k++)
                if (win < 0 && elig[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            e.rst = 1'b0;
            if (win >= 0) begin
`ifdef VRAM_ARB_VGA_PRIO_EN
                if (win != 0) m_ptr = (win + 1) % NREQ;
`else
                m_ptr = (win + 1) % NREQ;
`endif
                m_gnt      = '0;
                m_gnt[win] = 1'b1;
                m_addr     = req_addr[win*AW +: AW];
                m_wdata    = req_wdata[win*DW +: DW];
                e.we       = req_we[win];
                if (req_we[win]) begin
                    model_mem[m_addr] = m_wdata;
                end else begin
                    r.owner = win;
                    r.data  = model_mem[m_addr];
                    r.due   = upcoming + 2;
                    rd_q.push_back(r);
                end
            end else begin
                m_gnt = '0;
                e.we  = 1'b0;
            end
            e.gnt   = m_gnt;
            e.addr  = m_addr;
            e.wdata = m_wdata;
        end
        exp_q.push_back(e);
    endfunction

    task automatic applyStimulus();
        model_step();
        @(negedge clk);
    endtask

    task automatic setReq(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req[i]                 = 1'b1;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = addr;
        req_wdata[i*DW +: DW]  = wd;
    endtask

    task automatic waitGrant(input int i);
        int n;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!m_gnt[i] && n < 4 * NREQ);
        if (!m_gnt[i]) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL grant_timeout requester %0d: got no grant expected grant within %0d cycles", i, 4 * NREQ);
        end
    endtask

    // Monitor: compares registered outputs just after each edge against the queued predictions.
    logic [NREQ-1:0] exp_rv;
    exp_t            mon_e;
    rd_t             mon_r;
    always @(posedge clk) begin
        edge_n++;
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("gnt", 32'(gnt), 32'(mon_e.gnt));
            checkOutput("mem_we", 32'(mem_we), 32'(mon_e.we));
            checkOutput("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
            checkOutput("mem_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
            exp_rv = '0;
            if (rd_q.size() > 0 && rd_q[0].due <= edge_n) begin
                mon_r = rd_q.pop_front();
                exp_rv[mon_r.owner] = 1'b1;
                checkOutput("rvalid", 32'(rvalid), 32'(exp_rv));
                checkOutput("rdata", 32'(rdata), 32'(mon_r.data));
            end else begin
                checkOutput("rvalid", 32'(rvalid), 32'(exp_rv));
            end
            if (mon_e.rst) checkOutput("rdata_rst", 32'(rdata), 32'h0);
        end
    end

    initial begin
        for (int a = 0; a < 65536; a++) begin
            bram[a]      = init_val(a);
            model_mem[a] = init_val(a);
        end
        bram[16'h0040]      = 12'hABC;
        model_mem[16'h0040] = 12'hABC;
        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_ptr = 0; m_gnt = '0; m_addr = '0; m_wdata = '0;
        @(negedge clk);
        applyStimulus();
        applyStimulus();
        rst = 1'b0;

        $display("[TB] single read from requester 2");
        setReq(2, 1'b0, 16'h0040, 12'h000);
        waitGrant(2);
        req[2] = 1'b0;
        repeat (3) applyStimulus();

        $display("[TB] all requesters held continuously");
        for (int i = 0; i < NREQ; i++) setReq(i, 1'b0, AW'(16'h0040 + i), 12'h000);
        repeat (12) applyStimulus();
        req = '0;
        repeat (3) applyStimulus();

        $display("[TB] write then read back");
        setReq(1, 1'b1, 16'h0100, 12'h5A5);
        waitGrant(1);
        req[1] = 1'b0;
        setReq(3, 1'b0, 16'h0100, 12'h000);
        waitGrant(3);
        req[3] = 1'b0;
        repeat (3) applyStimulus();

        $display("[TB] requesters 0,1,2 contending");
        for (int i = 0; i < 3; i++) setReq(i, 1'b0, AW'(16'h0200 + i), 12'h000);
        repeat (12) applyStimulus();
        req = '0;
        repeat (3) applyStimulus();

        $display("[TB] reset one cycle after a read grant");
        setReq(1, 1'b0, 16'h0040, 12'h000);
        waitGrant(1);
        req[1] = 1'b0;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        setReq(1, 1'b0, 16'h0041, 12'h000);
        setReq(3, 1'b0, 16'h0042, 12'h000);
        applyStimulus();
        req = '0;
        repeat (3) applyStimulus();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt[i] || !req[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        setReq(i, ($urandom_range(0, 3) == 0), AW'(16'h0100 + $urandom_range(0, 15)), DW'($urandom));
                    else
                        req[i] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            applyStimulus();
        end
        rst = 1'b0;
        req = '0;
        repeat (5) applyStimulus();
        checkOutput("rd_drain", 32'(rd_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
